// File: rtl/mem_dump_reader_pkg.sv
// Shared debug-unit package: dump FSM state codes and the
// byte-beat bundle shared with the UART TX wrapper.
package mem_dump_reader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // One byte on a valid/ready link; a transfer
  // happens when valid && ready on a rising edge.
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } tx_beat_t;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_dump_reader_serializer.sv
// word_byte_serializer: loads a word, emits it MSB-first as bytes.
// Ports: clk, reset, load, word, ready -> beat (valid/data), last_byte.
module word_byte_serializer
  import mem_dump_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  output tx_beat_t              beat,
  output logic                  last_byte
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  valid;

  assign last_byte  = (idx == IW'(BPW - 1));
  assign beat.valid = valid;
  assign beat.data  = shreg[DATA_WIDTH-1 -: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last_byte) begin
        valid <= 1'b0;
      end else begin
        shreg <= shreg << 8;
        idx   <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Debug dump of data memory words 0..NUM_WORDS-1 as a byte stream.
// Ports: clk, reset, start, mem_addr/read_en/data, tx_valid/ready/data, busy, done.
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WORDS    = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int WW  = $clog2(READ_LATENCY + 1);

  // One extra bit so NUM_WORDS = 2^ADDR_WIDTH compares cleanly.
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(NUM_WORDS - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WW-1:0]         wait_cnt;
  tx_beat_t              beat;
  logic                  last_byte;
  logic                  load;
  logic                  xfer;

  assign load = (state == ST_LOAD);
  assign xfer = beat.valid && tx_ready;

  word_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .word      (mem_data),
    .ready     (tx_ready),
    .beat      (beat),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            addr  <= '0;
          end
        end
        ST_READ: begin
          wait_cnt <= WW'(READ_LATENCY);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WW'(1)) begin
            state <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        ST_LOAD: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer && last_byte) begin
            if ({1'b0, addr} == LAST_ADDR) begin
              state <= ST_DONE;
              addr  <= '0;
            end else begin
              state <= ST_READ;
              addr  <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_read_en = 1'b0;
    unique case (1'b1)
      (state == ST_READ),
      (state == ST_WAIT),
      (state == ST_LOAD),
      (state == ST_SEND): mem_read_en = 1'b1;
      default:            mem_read_en = 1'b0;
    endcase
  end

  assign busy     = mem_read_en;
  assign done     = (state == ST_DONE);
  assign mem_addr = addr;
  assign tx_valid = beat.valid;
  assign tx_data  = beat.data;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: three instances
// (2 words, 128 words, 2-cycle read latency).
`timescale 1ns/1ps
module tb_mem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tx_ready;
  logic start_a, start_b, start_c;

  logic [6:0]  addr_a, addr_b, addr_c;
  logic        ren_a, ren_b, ren_c;
  logic [31:0] md_a, md_b, md_c;
  logic        tv_a, tv_b, tv_c;
  logic [7:0]  td_a, td_b, td_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  mem_dump_reader #(
    .ADDR_WIDTH(7), .DATA_WIDTH(32),
    .NUM_WORDS(2), .READ_LATENCY(1)
  ) u_two (
    .clk(clk), .reset(reset), .start(start_a),
    .mem_addr(addr_a), .mem_read_en(ren_a),
    .mem_data(md_a), .tx_valid(tv_a),
    .tx_ready(tx_ready), .tx_data(td_a),
    .busy(busy_a), .done(done_a)
  );

  mem_dump_reader #(
    .ADDR_WIDTH(7), .DATA_WIDTH(32),
    .NUM_WORDS(128), .READ_LATENCY(1)
  ) u_full (
    .clk(clk), .reset(reset), .start(start_b),
    .mem_addr(addr_b), .mem_read_en(ren_b),
    .mem_data(md_b), .tx_valid(tv_b),
    .tx_ready(tx_ready), .tx_data(td_b),
    .busy(busy_b), .done(done_b)
  );

  mem_dump_reader #(
    .ADDR_WIDTH(7), .DATA_WIDTH(32),
    .NUM_WORDS(1), .READ_LATENCY(2)
  ) u_lat2 (
    .clk(clk), .reset(reset), .start(start_c),
    .mem_addr(addr_c), .mem_read_en(ren_c),
    .mem_data(md_c), .tx_valid(tv_c),
    .tx_ready(tx_ready), .tx_data(td_c),
    .busy(busy_c), .done(done_c)
  );

  // Memory models; unread cycles return a marker
  // so early captures show up as wrong bytes.
  logic [31:0] st1_c;
  always @(posedge clk) begin
    if (!ren_a)           md_a <= 32'h11111111;
    else if (addr_a == 0) md_a <= 32'hDEADBEEF;
    else if (addr_a == 1) md_a <= 32'h01234567;
    else                  md_a <= 32'h0;
    md_b <= {4{1'b0, addr_b}};
    if (!ren_c)           st1_c <= 32'h11111111;
    else if (addr_c == 0) st1_c <= 32'hCAFEF00D;
    else                  st1_c <= 32'h0;
    md_c <= st1_c;
  end

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
  int badaddr_a = 0, unstable_a = 0, stalls_a = 0;
  int wrap_b = 0;
  logic [6:0] peak_b = '0;
  logic [6:0] prev_addr_b = '0;
  logic prev_ren_b = 1'b0;
  logic hold_a = 1'b0;
  logic [7:0] hold_d_a = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold_a     = 1'b0;
      prev_ren_b = 1'b0;
    end else begin
      if (tv_a && tx_ready) qa.push_back(td_a);
      if (tv_b && tx_ready) qb.push_back(td_b);
      if (tv_c && tx_ready) qc.push_back(td_c);
      if (done_a) dcnt_a++;
      if (done_b) dcnt_b++;
      if (done_c) dcnt_c++;
      if (ren_a && addr_a > 7'd1) badaddr_a++;
      if (tv_a && !tx_ready) stalls_a++;
      if (hold_a && (!tv_a || td_a != hold_d_a)) unstable_a++;
      hold_a   = tv_a && !tx_ready;
      hold_d_a = td_a;
      if (ren_b && addr_b > peak_b) peak_b = addr_b;
      if (ren_b && prev_ren_b && prev_addr_b == 7'h7F && addr_b == 7'h00)
        wrap_b++;
      prev_ren_b  = ren_b;
      prev_addr_b = addr_b;
    end
  end

  int nvec = 0;
  int nerr = 0;
  logic [15:0] lfsr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dn(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic bs(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Entered in cycle 1 (the start cycle is cycle 0); returns
  // the cycle index in which done is seen, or max on timeout.
  task automatic run(input int w, input int max, input bit bp,
                     input int p1, input int p2,
                     output int n, output int gaps);
    n    = 1;
    gaps = 0;
    while (!dn(w) && n < max) begin
      if (bp) begin
        tx_ready = lfsr[0];
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      set_start(w, (n == p1) || (n == p2));
      tick();
      n++;
      if (!dn(w) && !bs(w)) gaps++;
    end
    set_start(w, 1'b0);
    tx_ready = 1'b1;
  endtask

  int n, gaps, dbase, bad;

  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    lfsr = 16'hACE1;
    tick();
    tick();

    chk("rst addr", addr_a, 0);
    chk("rst read_en", ren_a, 0);
    chk("rst tx_valid", tv_a, 0);
    chk("rst tx_data", td_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    reset = 1'b0;
    tick();

    // Two words, tx_ready held high.
    qa.delete();
    dbase = dcnt_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t1 busy", busy_a, 1);
    chk("t1 read_en", ren_a, 1);
    chk("t1 addr", addr_a, 0);
    run(0, 100, 1'b0, 0, 0, n, gaps);
    chk("t1 done", done_a, 1);
    chk("t1 cycles", n, 15);
    chk("t1 busy gaps", gaps, 0);
    tick();
    chk("t1 done pulse", done_a, 0);
    chk("t1 idle addr", addr_a, 0);
    chk("t1 nbytes", qa.size(), 8);
    chk("t1 word0", {qa[0], qa[1], qa[2], qa[3]}, 32'hDEADBEEF);
    chk("t1 word1", {qa[4], qa[5], qa[6], qa[7]}, 32'h01234567);
    chk("t1 done count", dcnt_a - dbase, 1);
    chk("t1 addr range", badaddr_a, 0);

    // Two words with pseudo-random backpressure.
    qa.delete();
    dbase = dcnt_a;
    unstable_a = 0;
    stalls_a = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run(0, 400, 1'b1, 0, 0, n, gaps);
    chk("t2 done", done_a, 1);
    tick();
    chk("t2 nbytes", qa.size(), 8);
    chk("t2 word0", {qa[0], qa[1], qa[2], qa[3]}, 32'hDEADBEEF);
    chk("t2 word1", {qa[4], qa[5], qa[6], qa[7]}, 32'h01234567);
    chk("t2 stable", unstable_a, 0);
    chk("t2 stalled", stalls_a != 0, 1);
    chk("t2 done count", dcnt_a - dbase, 1);

    // Full 128-word dump.
    qb.delete();
    dbase = dcnt_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    run(1, 1200, 1'b0, 0, 0, n, gaps);
    chk("t3 done", done_b, 1);
    chk("t3 cycles", n, 128 * 7 + 1);
    chk("t3 busy gaps", gaps, 0);
    tick();
    chk("t3 nbytes", qb.size(), 512);
    chk("t3 last word", {qb[508], qb[509], qb[510], qb[511]}, 32'h7F7F7F7F);
    bad = 0;
    for (int i = 0; i < qb.size(); i++)
      if (qb[i] !== 8'(i / 4)) bad++;
    chk("t3 byte errors", bad, 0);
    chk("t3 addr peak", peak_b, 7'h7F);
    chk("t3 addr wrap", wrap_b, 0);
    chk("t3 done count", dcnt_b - dbase, 1);

    // start re-pulsed mid-dump is ignored.
    qb.delete();
    dbase = dcnt_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    run(1, 1200, 1'b0, 5, 20, n, gaps);
    chk("t4 cycles", n, 128 * 7 + 1);
    tick();
    chk("t4 nbytes", qb.size(), 512);
    chk("t4 done count", dcnt_b - dbase, 1);

    // A fresh start after done restarts from address 0.
    qb.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t4 restart addr", addr_b, 0);
    chk("t4 restart read_en", ren_b, 1);
    run(1, 1200, 1'b0, 0, 0, n, gaps);
    chk("t4 restart done", done_b, 1);
    tick();
    chk("t4 restart w0", {qb[0], qb[1], qb[2], qb[3]}, 32'h00000000);
    chk("t4 restart w1", {qb[4], qb[5], qb[6], qb[7]}, 32'h01010101);

    // Async reset during SEND after two bytes of word 0.
    qa.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    chk("t5 bytes before", qa.size(), 2);
    chk("t5 tx_data before", td_a, 8'hBE);
    #2 reset = 1'b1;
    #1;
    chk("t5 tx_valid", tv_a, 0);
    chk("t5 busy", busy_a, 0);
    chk("t5 read_en", ren_a, 0);
    chk("t5 addr", addr_a, 0);
    chk("t5 done", done_a, 0);
    #2 reset = 1'b0;
    dbase = dcnt_a;
    repeat (3) tick();
    chk("t5 no done", dcnt_a - dbase, 0);
    chk("t5 idle busy", busy_a, 0);
    qa.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    run(0, 100, 1'b0, 0, 0, n, gaps);
    chk("t5 redo cycles", n, 15);
    tick();
    chk("t5 redo word0", {qa[0], qa[1], qa[2], qa[3]}, 32'hDEADBEEF);
    chk("t5 redo word1", {qa[4], qa[5], qa[6], qa[7]}, 32'h01234567);

    // Two-cycle read latency.
    qc.delete();
    dbase = dcnt_c;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    run(2, 100, 1'b0, 0, 0, n, gaps);
    chk("t6 done", done_c, 1);
    chk("t6 cycles", n, 9);
    tick();
    chk("t6 nbytes", qc.size(), 4);
    chk("t6 word", {qc[0], qc[1], qc[2], qc[3]}, 32'hCAFEF00D);
    chk("t6 done count", dcnt_c - dbase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
